// File: rtl/uart_rx_deser_if.sv
// Bus bundle between the UART RX deserializer and its environment:
// serial input, baud/parity configuration, FIFO write side and error flags.
// The slave modport is the deserializer; the master modport is whoever
// drives the line and consumes the FIFO writes and error reports.
interface uart_rx_deser_if #(
  parameter int DIV_W = 16
);
  logic             rx;
  logic [DIV_W-1:0] baud_div;
  logic             parity_odd;
  logic             fifo_full;
  logic             err_clr;
  logic [7:0]       fifo_din;
  logic             fifo_wr_en;
  logic             busy;
  logic             frame_err;
  logic             parity_err;
  logic             overrun;
  logic [2:0]       err_sticky;

  modport slave (
    input  rx, baud_div, parity_odd, fifo_full, err_clr,
    output fifo_din, fifo_wr_en, busy, frame_err, parity_err, overrun, err_sticky
  );

  modport master (
    output rx, baud_div, parity_odd, fifo_full, err_clr,
    input  fifo_din, fifo_wr_en, busy, frame_err, parity_err, overrun, err_sticky
  );
endinterface

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: synchronizes rx into wr_clk, oversamples it OVS
// times per bit, frames 8N1 characters and pushes each good byte into the RX
// FIFO with a one-cycle write strobe. Frame/parity/overrun errors are
// reported as one-cycle pulses and as sticky flags {overrun, parity, frame}.
// Optional feature: define UART_RX_PARITY_EN for 8E1/8O1 framing with a
// parity bit between the data and the stop bit.
module uart_rx_deser #(
  parameter int OVS   = 16,
  parameter int DIV_W = 16
) (
  input  logic             wr_clk,
  input  logic             rst,
  uart_rx_deser_if.slave   bus
);

  localparam int SW = $clog2(OVS);
  localparam logic [SW-1:0] S_MID = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t           r_state;
  logic             r_sync1, r_sync2, r_rxs_d;
  logic [DIV_W-1:0] r_div_cnt, r_div_lim;
  logic [SW-1:0]    r_s_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift, r_din;
  logic             r_wr_en, r_frame, r_ovr;
  logic [2:0]       r_sticky;
  logic             w_rxs, w_fall, w_tick, w_bit_pt;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_par_pulse;
  assign bus.parity_err = r_par_pulse;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = bus.parity_odd;
  assign bus.parity_err      = 1'b0;
`endif

  assign w_rxs    = r_sync2;
  assign w_fall   = r_rxs_d & ~w_rxs;
  // The divider only runs outside IDLE, so a tick can never fire in IDLE.
  assign w_tick   = (r_state != S_IDLE) && (r_div_cnt == r_div_lim - DIV_W'(1));
  // Data, parity and stop bits are all sampled one full bit after mid-start.
  assign w_bit_pt = w_tick && (r_s_cnt == S_END);

  assign bus.fifo_din   = r_din;
  assign bus.fifo_wr_en = r_wr_en;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.frame_err  = r_frame;
  assign bus.overrun    = r_ovr;
  assign bus.err_sticky = r_sticky;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
      r_rxs_d <= r_sync2;
    end
  end

  // Receive FSM with tick/sample counters and registered strobes/flags.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div_cnt <= '0;
      r_div_lim <= DIV_W'(1);
      r_s_cnt   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_din     <= '0;
      r_wr_en   <= 1'b0;
      r_frame   <= 1'b0;
      r_ovr     <= 1'b0;
      r_sticky  <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad   <= 1'b0;
      r_par_pulse <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      r_frame <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_pulse <= 1'b0;
`endif
      // Clear first; any set below in the same cycle overrides it.
      if (bus.err_clr) r_sticky <= '0;

      if (r_state == S_IDLE) r_div_cnt <= '0;
      else if (w_tick)       r_div_cnt <= '0;
      else                   r_div_cnt <= r_div_cnt + DIV_W'(1);

      if (w_tick) r_s_cnt <= (r_s_cnt == S_END) ? '0 : r_s_cnt + SW'(1);

      case (r_state)
        S_IDLE: begin
          // Baud divisor is only picked up here, so a mid-character change is ignored.
          r_div_lim <= (bus.baud_div == '0) ? DIV_W'(1) : bus.baud_div;
          if (w_fall) begin
            r_state <= S_START;
            r_s_cnt <= '0;
          end
        end
        S_START: begin
          if (w_tick && r_s_cnt == S_MID) begin
            if (!w_rxs) begin
              r_state   <= S_DATA;
              r_s_cnt   <= '0;
              r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              r_par_bad <= 1'b0;
`endif
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_bit_pt) begin
            r_shift   <= {w_rxs, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
        S_PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (w_bit_pt) begin
            r_par_bad <= (w_rxs != ((^r_shift) ^ bus.parity_odd));
            r_state   <= S_STOP;
          end
`else
          r_state <= S_IDLE;
`endif
        end
        S_STOP: begin
          if (w_bit_pt) begin
            if (!w_rxs) begin
              r_frame     <= 1'b1;
              r_sticky[0] <= 1'b1;
              r_state     <= S_BREAK;
            end else begin
              r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (r_par_bad) begin
                r_par_pulse <= 1'b1;
                r_sticky[1] <= 1'b1;
              end else
`endif
              if (bus.fifo_full) begin
                r_ovr       <= 1'b1;
                r_sticky[2] <= 1'b1;
              end else begin
                r_wr_en <= 1'b1;
                r_din   <= r_shift;
              end
            end
          end
        end
        S_BREAK: begin
          if (w_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Testbench for uart_rx_deser: table of characters driven on rx, with a
// scoreboard queue of expected FIFO pushes / error pulses checked by a
// monitor, plus hand-written glitch, divisor-0, reset and parity sequences.
module tb_uart_rx_deser;
  localparam int OVS   = 16;
  localparam int DIV_W = 16;
  localparam int BIT   = OVS * 4;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_NOM = 675;   // 10.5 bits * 64 + 3
`else
  localparam int LAT_NOM = 611;   // 9.5 bits * 64 + 3
`endif

  logic wr_clk = 1'b0;
  logic rst    = 1'b1;
  always #5 wr_clk = ~wr_clk;

  uart_rx_deser_if #(.DIV_W(DIV_W)) bus ();
  uart_rx_deser #(.OVS(OVS), .DIV_W(DIV_W)) dut (.wr_clk(wr_clk), .rst(rst), .bus(bus));

  typedef enum int {EV_PUSH = 0, EV_FRAME = 1, EV_OVR = 2, EV_PAR = 3} ev_t;
  typedef struct {ev_t kind; logic [7:0] data; bit chk_lat; time t0;} exp_t;
  typedef struct {
    logic [7:0] data; bit stop; bit full; int low_hold; int gap;
    ev_t ev; logic [2:0] sticky; bit lat;
  } vec_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   bit_len = BIT;
  logic [7:0] last_din = 8'h00;
`ifdef UART_RX_PARITY_EN
  bit par_flip = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge wr_clk);
  endtask

  task automatic send_char(input logic [7:0] d, input bit stop);
    bus.rx = 1'b0;
    wait_cyc(bit_len);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      wait_cyc(bit_len);
      if (i == 3) chk("busy_mid_char", bus.busy, 1);
    end
`ifdef UART_RX_PARITY_EN
    bus.rx = (^d) ^ bus.parity_odd ^ par_flip;
    wait_cyc(bit_len);
`endif
    bus.rx = stop;
    wait_cyc(bit_len);
  endtask

  task automatic expect_ev(input ev_t k, input logic [7:0] d, input bit lat);
    exp_t e;
    e.kind = k; e.data = d; e.chk_lat = lat; e.t0 = $time;
    q.push_back(e);
  endtask

  // Monitor: every strobe/pulse cycle must match the head of the scoreboard.
  exp_t m_e;
  int   m_nev, m_lat;
  ev_t  m_kind;
  always @(negedge wr_clk) begin
    if (!rst) begin
      m_nev = int'(bus.fifo_wr_en) + int'(bus.frame_err) + int'(bus.overrun) + int'(bus.parity_err);
      if (m_nev != 0) begin
        chk("one_event_per_cycle", m_nev, 1);
        m_kind = bus.fifo_wr_en ? EV_PUSH : bus.frame_err ? EV_FRAME : bus.overrun ? EV_OVR : EV_PAR;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: got kind %0d din %0h, expected none (t=%0t)", m_kind, bus.fifo_din, $time);
        end else begin
          m_e = q.pop_front();
          chk("event_kind", m_kind, m_e.kind);
          if (m_kind == EV_PUSH) begin
            chk("fifo_din", bus.fifo_din, m_e.data);
            last_din = bus.fifo_din;
          end else begin
            chk("fifo_din_held", bus.fifo_din, last_din);
          end
          if (m_e.chk_lat) begin
            m_lat = int'(($time - m_e.t0) / 10);
            chk("push_latency_in_window", (m_lat >= LAT_NOM - 3 && m_lat <= LAT_NOM + 3), 1);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 0,    20, EV_PUSH,  3'b000, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 0,    0,  EV_PUSH,  3'b000, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 0,    0,  EV_PUSH,  3'b000, 1'b0};
    vecs[3] = '{8'h55, 1'b1, 1'b0, 0,    20, EV_PUSH,  3'b000, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1000, 20, EV_FRAME, 3'b001, 1'b0};
    vecs[5] = '{8'h12, 1'b1, 1'b0, 0,    20, EV_PUSH,  3'b001, 1'b0};
    vecs[6] = '{8'h77, 1'b1, 1'b1, 0,    20, EV_OVR,   3'b101, 1'b0};

    bus.rx = 1'b1; bus.baud_div = DIV_W'(4); bus.parity_odd = 1'b0;
    bus.fifo_full = 1'b0; bus.err_clr = 1'b0;
    rst = 1'b1;
    wait_cyc(4);
    chk("reset_fifo_wr_en", bus.fifo_wr_en, 0);
    chk("reset_fifo_din", bus.fifo_din, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_frame_err", bus.frame_err, 0);
    chk("reset_parity_err", bus.parity_err, 0);
    chk("reset_overrun", bus.overrun, 0);
    chk("reset_err_sticky", bus.err_sticky, 0);
    rst = 1'b0;
    wait_cyc(5);

    for (int i = 0; i < 7; i++) begin
      expect_ev(vecs[i].ev, vecs[i].data, vecs[i].lat);
      bus.fifo_full = vecs[i].full;
      send_char(vecs[i].data, vecs[i].stop);
      bus.rx = 1'b0;
      wait_cyc(vecs[i].low_hold);
      bus.rx = 1'b1;
      wait_cyc(vecs[i].gap);
      bus.fifo_full = 1'b0;
      if (vecs[i].gap > 0) chk("busy_idle_after_char", bus.busy, 0);
      chk("err_sticky_after_char", bus.err_sticky, vecs[i].sticky);
      $display("vec %0d: data %0h stop %0b full %0b sticky %0b", i, vecs[i].data, vecs[i].stop, vecs[i].full, bus.err_sticky);
    end

    // Sticky clear.
    bus.err_clr = 1'b1;
    wait_cyc(1);
    bus.err_clr = 1'b0;
    wait_cyc(1);
    chk("err_sticky_cleared", bus.err_sticky, 0);
    $display("err_clr: sticky %0b", bus.err_sticky);

    // Glitch shorter than half a bit: no push, no error, back to idle.
    bus.rx = 1'b0;
    wait_cyc(10);
    chk("busy_during_glitch", bus.busy, 1);
    wait_cyc(10);
    bus.rx = 1'b1;
    wait_cyc(60);
    chk("busy_after_glitch", bus.busy, 0);
    $display("glitch: busy %0b", bus.busy);

    // Divisor 0 behaves as 1: 16 cycles per bit.
    bus.baud_div = '0;
    bit_len = OVS;
    expect_ev(EV_PUSH, 8'h81, 1'b0);
    send_char(8'h81, 1'b1);
    wait_cyc(10);
    chk("busy_after_div0_char", bus.busy, 0);
    $display("baud_div=0: char 81 sent");
    bus.baud_div = DIV_W'(4);
    bit_len = BIT;

`ifdef UART_RX_PARITY_EN
    bus.parity_odd = 1'b0;
    par_flip = 1'b0;
    expect_ev(EV_PUSH, 8'h01, 1'b0);
    send_char(8'h01, 1'b1);
    wait_cyc(20);
    $display("parity even good: char 01");
    par_flip = 1'b1;
    expect_ev(EV_PAR, 8'h01, 1'b0);
    send_char(8'h01, 1'b1);
    wait_cyc(20);
    chk("err_sticky_parity", bus.err_sticky, 3'b010);
    $display("parity even bad: sticky %0b", bus.err_sticky);
    par_flip = 1'b0;
    bus.parity_odd = 1'b1;
    expect_ev(EV_PUSH, 8'h01, 1'b0);
    send_char(8'h01, 1'b1);
    wait_cyc(20);
    $display("parity odd good: char 01");
    bus.parity_odd = 1'b0;
`endif

    // Reset in the middle of the data bits: idle next cycle, nothing pushed.
    bus.rx = 1'b0;
    wait_cyc(BIT * 3);
    chk("busy_mid_data_before_reset", bus.busy, 1);
    rst = 1'b1;
    bus.rx = 1'b1;
    wait_cyc(1);
    chk("busy_after_reset", bus.busy, 0);
    chk("wr_en_after_reset", bus.fifo_wr_en, 0);
    rst = 1'b0;
    wait_cyc(BIT * 11);
    chk("busy_long_after_reset", bus.busy, 0);
    $display("reset mid-data: busy %0b", bus.busy);

    wait_cyc(50);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
